// File: rtl/cache_mem_pkg.sv
// Shared definitions for the cache_controller <-> main_memory_responder block interface:
// responder FSM states and the default block geometry / timing constants.
package cache_mem_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_XFER = 2'd2,
        ST_DONE = 2'd3
    } mem_state_e;

    localparam int BURST_LEN_DEF  = 4;
    localparam int LATENCY_DEF    = 4;
    localparam int DATA_WIDTH_DEF = 32;

endpackage

// File: rtl/mem_word_array.sv
// Word-addressed backing store: synchronous write, asynchronous read, no reset, so
// contents survive a system reset.
module mem_word_array #(
    parameter int DEPTH = 1024,
    parameter int DW    = 32,
    parameter int AW    = 10
) (
    input  logic          clk,
    input  logic          we_i,
    input  logic [AW-1:0] addr_i,
    input  logic [DW-1:0] wdata_i,
    output logic [DW-1:0] rdata_o
);

    logic [DW-1:0] mem_q [DEPTH];

    always_ff @(posedge clk) begin
        if (we_i) begin
            mem_q[addr_i] <= wdata_i;
        end
    end

    assign rdata_o = mem_q[addr_i];

endmodule

// File: rtl/main_memory_responder.sv
// Memory-side responder for cache block reads/write-backs with a fixed access latency.
// Define MEM_RESP_ERR_EN to add the sticky err_mem protocol-violation output.
module main_memory_responder
    import cache_mem_pkg::*;
#(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = DATA_WIDTH_DEF,
    parameter int MEM_WORDS  = 1024,
    parameter int BURST_LEN  = BURST_LEN_DEF,
    parameter int LATENCY    = LATENCY_DEF
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [ADDR_WIDTH-1:0] addr_mem,
    input  logic                  read_mem,
    input  logic                  write_mem,
    inout  wire  [DATA_WIDTH-1:0] data_mem,
    output logic                  ready_mem
`ifdef MEM_RESP_ERR_EN
    ,
    output logic                  err_mem
`endif
);

    localparam int IDX_W = $clog2(MEM_WORDS);
    localparam int BW    = $clog2(BURST_LEN);
    localparam int BCW   = (BW > 0) ? BW : 1;
    localparam int LCW   = (LATENCY > 1) ? $clog2(LATENCY) : 1;

    mem_state_e       state_q;
    logic [LCW-1:0]   lat_cnt_q;
    logic [BCW-1:0]   beat_q;
    logic [IDX_W-1:0] base_q;
    logic             dir_wr_q;
    logic             ready_q;

    logic [IDX_W-1:0]      req_base;
    logic [IDX_W-1:0]      word_idx;
    logic                  accept;
    logic                  last_beat;
    logic                  mem_we;
    logic                  drive_en;
    logic [DATA_WIDTH-1:0] rd_data;
    logic                  unused_addr;

    assign req_base  = addr_mem[2 +: IDX_W] & ~IDX_W'(BURST_LEN - 1);
    assign word_idx  = base_q | IDX_W'(beat_q);
    assign last_beat = (beat_q == BCW'(BURST_LEN - 1));

    // DONE only re-accepts the opposite direction, so a held request cannot retrigger.
    assign accept = ((state_q == ST_IDLE) && (read_mem || write_mem)) ||
                    ((state_q == ST_DONE) && (dir_wr_q ? (read_mem && !write_mem)
                                                       : (write_mem && !read_mem)));

    assign mem_we   = (state_q == ST_XFER) && dir_wr_q;
    assign drive_en = (state_q == ST_XFER) && !dir_wr_q && !write_mem;
    assign data_mem = drive_en ? rd_data : 'z;
    assign ready_mem = ready_q;

    mem_word_array #(
        .DEPTH (MEM_WORDS),
        .DW    (DATA_WIDTH),
        .AW    (IDX_W)
    ) u_array (
        .clk     (clk),
        .we_i    (mem_we),
        .addr_i  (word_idx),
        .wdata_i (data_mem),
        .rdata_o (rd_data)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            ready_q   <= 1'b1;
            lat_cnt_q <= '0;
            beat_q    <= '0;
            base_q    <= '0;
            dir_wr_q  <= 1'b0;
        end else if (accept) begin
            state_q   <= ST_WAIT;
            ready_q   <= 1'b0;
            lat_cnt_q <= LCW'(LATENCY - 1);
            beat_q    <= '0;
            base_q    <= req_base;
            dir_wr_q  <= write_mem;
        end else begin
            case (state_q)
                ST_WAIT: begin
                    if (lat_cnt_q == '0) begin
                        state_q <= ST_XFER;
                        ready_q <= 1'b1;
                    end else begin
                        lat_cnt_q <= lat_cnt_q - 1'b1;
                    end
                end
                ST_XFER: begin
                    if (last_beat) begin
                        state_q <= ST_DONE;
                        beat_q  <= '0;
                    end else begin
                        beat_q <= beat_q + 1'b1;
                    end
                end
                ST_DONE: begin
                    if (!read_mem && !write_mem) begin
                        state_q <= ST_IDLE;
                    end
                end
                default: ;
            endcase
        end
    end

`ifdef MEM_RESP_ERR_EN
    logic err_q;
    logic err_hit;

    always_comb begin
        err_hit = 1'b0;
        if ((state_q == ST_IDLE) && read_mem && write_mem) begin
            err_hit = 1'b1;
        end
        if ((state_q == ST_XFER) && !dir_wr_q && write_mem) begin
            err_hit = 1'b1;
        end
        if (accept && (addr_mem[ADDR_WIDTH-1:IDX_W+2] != '0)) begin
            err_hit = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            err_q <= 1'b0;
        end else if (err_hit) begin
            err_q <= 1'b1;
        end
    end

    assign err_mem     = err_q;
    assign unused_addr = ^addr_mem[1:0];
`else
    assign unused_addr = ^{addr_mem[ADDR_WIDTH-1:IDX_W+2], addr_mem[1:0]};
`endif

endmodule

// File: tb/tb_main_memory_responder.sv
// Directed + randomized bench for main_memory_responder against a word-array model of
// the backing store; err_mem checks are compiled in with MEM_RESP_ERR_EN.
module tb_main_memory_responder;

    localparam int LAT   = 4;
    localparam int BURST = 4;
    localparam int WORDS = 1024;

    logic        clk = 1'b0;
    logic        reset;
    logic        read_mem;
    logic        write_mem;
    logic [31:0] addr_mem;
    wire  [31:0] data_mem;
    logic        ready_mem;
    logic        tb_drv;
    logic [31:0] tb_data;
`ifdef MEM_RESP_ERR_EN
    logic        err_mem;
`endif

    logic [31:0] ref_mem [WORDS];
    int total = 0;
    int bad   = 0;

    assign data_mem = tb_drv ? tb_data : 'z;

    always #5 clk = ~clk;

    main_memory_responder dut (
        .clk       (clk),
        .reset     (reset),
        .addr_mem  (addr_mem),
        .read_mem  (read_mem),
        .write_mem (write_mem),
        .data_mem  (data_mem),
        .ready_mem (ready_mem)
`ifdef MEM_RESP_ERR_EN
        ,
        .err_mem   (err_mem)
`endif
    );

    function automatic int unsigned blk_base(input logic [31:0] a);
        int unsigned w;
        w = (a >> 2) % WORDS;
        return w - (w % BURST);
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic idle(input int n);
        read_mem  = 1'b0;
        write_mem = 1'b0;
        repeat (n) @(negedge clk);
    endtask

    // Called at a negedge when the responder will accept the request on the next edge.
    task automatic burst(input bit wr, input bit both, input logic [31:0] addr,
                         input bit hold, input logic [3:0][31:0] wd);
        int unsigned b;
        b = blk_base(addr);
        write_mem = wr;
        read_mem  = !wr || both;
        addr_mem  = addr;
        @(negedge clk);
        if (!hold) begin
            write_mem = 1'b0;
            read_mem  = 1'b0;
        end
        addr_mem = $urandom;
        for (int i = 0; i < LAT; i++) begin
            chk("wait_low", {31'd0, ready_mem}, 32'd0);
            @(negedge clk);
        end
        for (int k = 0; k < BURST; k++) begin
            chk("beat_ready", {31'd0, ready_mem}, 32'd1);
            if (wr) begin
                tb_drv     = 1'b1;
                tb_data    = wd[k];
                ref_mem[b + k] = wd[k];
            end else begin
                chk("rd_data", data_mem, ref_mem[b + k]);
            end
            @(negedge clk);
        end
        tb_drv = 1'b0;
        chk("done_ready", {31'd0, ready_mem}, 32'd1);
        $display("burst %s addr=%h base=%0d hold=%0d", wr ? "write" : "read", addr, b, hold);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [3:0][31:0] wd;
        logic [31:0] a;
        bit wr, hold;

        reset = 1'b1; read_mem = 1'b0; write_mem = 1'b0; addr_mem = '0;
        tb_drv = 1'b0; tb_data = '0;
        repeat (4) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        chk("reset_ready", {31'd0, ready_mem}, 32'd1);
`ifdef MEM_RESP_ERR_EN
        chk("reset_err", {31'd0, err_mem}, 32'd0);
`endif

        // Fill every block through the protocol so all later reads are checkable.
        for (int blk = 0; blk < WORDS / BURST; blk++) begin
            for (int k = 0; k < BURST; k++) wd[k] = $urandom;
            a = ($urandom & 32'hFFFF_F00F) | (32'(blk) << 4);
            idle(1);
            burst(1'b1, 1'b0, a, 1'b0, wd);
        end

        // Preload 0x24..0x27, then read it back through a high-aliased address.
        wd = {32'h3333, 32'h2222, 32'h1111, 32'h0000};
        idle(1);
        burst(1'b1, 1'b0, 32'h0000_0090, 1'b0, wd);
        idle(1);
        burst(1'b0, 1'b0, 32'hC000_0091, 1'b0, wd);
        repeat (3) begin
            chk("after_read_ready", {31'd0, ready_mem}, 32'd1);
            @(negedge clk);
        end

        // Write-back held into DONE, then the fill is accepted straight from DONE.
        wd = {32'hDDDD, 32'hCCCC, 32'hBBBB, 32'hAAAA};
        idle(1);
        burst(1'b1, 1'b0, 32'h8000_8018, 1'b1, wd);
        burst(1'b0, 1'b0, 32'h8000_8018, 1'b0, wd);

        // A held read yields exactly one burst and then parks.
        idle(1);
        burst(1'b0, 1'b0, 32'h0000_0090, 1'b1, wd);
        repeat (40) begin
            chk("held_no_retrigger", {31'd0, ready_mem}, 32'd1);
            @(negedge clk);
        end
        idle(1);
        burst(1'b0, 1'b0, 32'h0000_0094, 1'b0, wd);

        // Async reset in the middle of the latency window.
        idle(1);
        read_mem = 1'b1;
        addr_mem = 32'h0000_0200;
        @(negedge clk);
        read_mem = 1'b0;
        chk("pre_reset_wait", {31'd0, ready_mem}, 32'd0);
        @(negedge clk);
        #2 reset = 1'b1;
        #1 chk("async_reset_ready", {31'd0, ready_mem}, 32'd1);
        @(negedge clk);
        reset = 1'b0;
        repeat (8) begin
            chk("no_beats_after_reset", {31'd0, ready_mem}, 32'd1);
            @(negedge clk);
        end
        burst(1'b0, 1'b0, 32'h0000_0200, 1'b0, wd);

        // Randomized traffic, sometimes chaining write-back -> fill from DONE.
        for (int n = 0; n < 40; n++) begin
            wr   = 1'($urandom_range(0, 1));
            hold = 1'($urandom_range(0, 1));
            a    = $urandom;
            for (int k = 0; k < BURST; k++) wd[k] = $urandom;
            idle(1);
            burst(wr, 1'b0, a, hold, wd);
            if (hold && $urandom_range(0, 1) == 1) begin
                burst(!wr, 1'b0, a, 1'b0, wd);
            end
        end

        // Both requests high in IDLE: the write wins.
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
`ifdef MEM_RESP_ERR_EN
        chk("err_cleared", {31'd0, err_mem}, 32'd0);
`endif
        wd = {32'h4444_0003, 32'h4444_0002, 32'h4444_0001, 32'h4444_0000};
        burst(1'b1, 1'b1, 32'h0000_0040, 1'b0, wd);
`ifdef MEM_RESP_ERR_EN
        repeat (5) begin
            chk("err_sticky", {31'd0, err_mem}, 32'd1);
            @(negedge clk);
        end
`endif
        idle(1);
        burst(1'b0, 1'b0, 32'h0000_0040, 1'b0, wd);

        idle(2);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
